// File: rtl/collide_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// collide_pkg: state encoding and operand layout shared by collide_sched.
// Rev 1.0
// ------------------------------------------------------------------
package collide_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam int c_W   = 32;
    localparam int c_OPW = 6 * c_W;

    // Operand bundle is {z2,y2,x2,z1,y1,x1}, x1 in the LSBs.
    localparam int c_X1_OFF = 0 * c_W;
    localparam int c_Y1_OFF = 1 * c_W;
    localparam int c_Z1_OFF = 2 * c_W;
    localparam int c_X2_OFF = 3 * c_W;
    localparam int c_Y2_OFF = 4 * c_W;
    localparam int c_Z2_OFF = 5 * c_W;

    localparam int c_TMO_DEFAULT = 1023;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ------------------------------------------------------------------
// rr_pick: combinational round-robin pick, first valid at or after ptr.
// Rev 1.0
// ------------------------------------------------------------------
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         i_valid,
    input  logic [$clog2(NREQ)-1:0] i_ptr,
    output logic [NREQ-1:0]         o_grant,
    output logic [$clog2(NREQ)-1:0] o_idx
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] w_pos;
    logic          w_found;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_pos   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_pos = IW'((int'(i_ptr) + k) % NREQ);
            if (!w_found && i_valid[w_pos]) begin
                w_found        = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_idx          = w_pos;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/collide_sched.sv
`default_nettype none
// ------------------------------------------------------------------
// collide_sched: round-robin scheduler sharing one collision core, with timeout.
// Rev 1.0
// ------------------------------------------------------------------
module collide_sched
    import collide_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = c_W,
    parameter int OPW  = c_OPW,
    parameter int TMO  = c_TMO_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*OPW-1:0]     req_op,
    output logic [NREQ-1:0]         req_ready,
    output logic [OPW-1:0]          core_op,
    output logic                    core_start,
    output logic                    core_abort,
    input  logic                    core_done,
    input  logic                    core_ret,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic                    rsp_hit,
    output logic                    rsp_tmo,
    output logic                    busy
);

    localparam int            IW         = $clog2(NREQ);
    localparam int            CW         = $clog2(TMO + 1);
    localparam logic [CW-1:0] c_CNT_LAST = CW'(TMO - 1);

    if (OPW != 6 * W || NREQ < 2 || NREQ > 8) begin : g_param_check
        $error("collide_sched: OPW must be 6*W and NREQ within 2..8");
    end

    state_t          r_state, w_next;
    logic [IW-1:0]   r_ptr, w_idx, w_ptr_nxt;
    logic [NREQ-1:0] w_grant;
    logic [CW-1:0]   r_cnt;
    logic [OPW-1:0]  r_core_op;
    logic [IW-1:0]   r_rsp_id;
    logic            r_hit, r_tmo;
    logic            w_hs, w_last, w_start, w_abort;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .i_valid (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    assign w_hs      = (r_state == ST_IDLE) && (|w_grant);
    assign w_last    = (r_cnt == c_CNT_LAST);
    assign w_ptr_nxt = (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + IW'(1);

    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_abort   = 1'b0;
        req_ready = '0;
        case (r_state)
            ST_IDLE: begin
                req_ready = w_grant;
                if (w_hs) w_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                w_start = 1'b1;
                w_next  = ST_WAIT;
            end
            ST_WAIT: begin
                // A done arriving on the last counted cycle wins over the timeout.
                if (core_done) begin
                    w_next = ST_RESP;
                end else if (w_last) begin
                    w_abort = 1'b1;
                    w_next  = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_core_op <= '0;
            r_rsp_id  <= '0;
            r_hit     <= 1'b0;
            r_tmo     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hs) begin
                        r_core_op <= req_op[w_idx*OPW +: OPW];
                        r_rsp_id  <= w_idx;
                        r_ptr     <= w_ptr_nxt;
                    end
                end
                ST_ISSUE: r_cnt <= '0;
                ST_WAIT: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (core_done) begin
                        r_hit <= core_ret;
                        r_tmo <= 1'b0;
                    end else if (w_last) begin
                        r_hit <= 1'b0;
                        r_tmo <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign core_op    = r_core_op;
    assign core_start = w_start;
    assign core_abort = w_abort;
    assign rsp_valid  = (r_state == ST_RESP);
    assign rsp_id     = r_rsp_id;
    assign rsp_hit    = r_hit;
    assign rsp_tmo    = r_tmo;
    assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_collide_sched.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_collide_sched: directed self-checking bench for collide_sched.
// Rev 1.0
// ------------------------------------------------------------------
module tb_collide_sched;

    localparam int NREQ = 4;
    localparam int OPW  = 192;

    localparam logic [OPW-1:0] c_BUNDLE0 = {32'h4114E9B3, 32'h3FA746B2, 32'hC181D8D2,
                                            32'h40FE5B6E, 32'hBF14C719, 32'hC18FB09A};

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*OPW-1:0] req_op;
    logic                core_done, core_ret, rsp_ready;

    // dA: default timeout; dT: timeout of 16 cycles
    logic [NREQ-1:0] a_req_ready, t_req_ready;
    logic [OPW-1:0]  a_core_op, t_core_op;
    logic            a_core_start, a_core_abort, a_rsp_valid, a_rsp_hit, a_rsp_tmo, a_busy;
    logic            t_core_start, t_core_abort, t_rsp_valid, t_rsp_hit, t_rsp_tmo, t_busy;
    logic [1:0]      a_rsp_id, t_rsp_id;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    collide_sched #(.NREQ(NREQ)) dA (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
        .req_ready(a_req_ready), .core_op(a_core_op), .core_start(a_core_start),
        .core_abort(a_core_abort), .core_done(core_done), .core_ret(core_ret),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(a_rsp_id),
        .rsp_hit(a_rsp_hit), .rsp_tmo(a_rsp_tmo), .busy(a_busy)
    );

    collide_sched #(.NREQ(NREQ), .TMO(16)) dT (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
        .req_ready(t_req_ready), .core_op(t_core_op), .core_start(t_core_start),
        .core_abort(t_core_abort), .core_done(core_done), .core_ret(core_ret),
        .rsp_valid(t_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(t_rsp_id),
        .rsp_hit(t_rsp_hit), .rsp_tmo(t_rsp_tmo), .busy(t_busy)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; req_valid = '0; req_op = '0;
        core_done = 1'b0; core_ret = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = '0; req_op = '0;
        core_done = 1'b0; core_ret = 1'b0; rsp_ready = 1'b0;
        #1;
        checks++; if (a_req_ready !== 4'b0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", a_req_ready); end
        checks++; if (a_core_op !== '0) begin failures++; $display("FAIL reset_core_op got=%h exp=0", a_core_op); end
        checks++; if (a_core_start !== 1'b0) begin failures++; $display("FAIL reset_core_start got=%b exp=0", a_core_start); end
        checks++; if (a_core_abort !== 1'b0) begin failures++; $display("FAIL reset_core_abort got=%b exp=0", a_core_abort); end
        checks++; if (a_rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", a_rsp_valid); end
        checks++; if (a_rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_id got=%0d exp=0", a_rsp_id); end
        checks++; if ({a_rsp_hit, a_rsp_tmo} !== 2'b00) begin failures++; $display("FAIL reset_hit_tmo got=%b exp=00", {a_rsp_hit, a_rsp_tmo}); end
        checks++; if ({a_busy, t_busy} !== 2'b00) begin failures++; $display("FAIL reset_busy got=%b exp=00", {a_busy, t_busy}); end
    endtask

    task automatic test_single();
        int s = -1; int starts = 0; int rsp_s = -1;
        do_reset();
        @(negedge clk);
        req_valid = 4'b0001; req_op[0 +: OPW] = c_BUNDLE0; core_ret = 1'b1;
        #1;
        checks++; if (a_req_ready !== 4'b0001) begin failures++; $display("FAIL single_grant got=%b exp=0001", a_req_ready); end
        for (int c = 0; c < 60 && rsp_s < 0; c++) begin
            @(negedge clk);
            req_valid = '0;
            if (s >= 0) s++;
            core_done = (s == 20);
            #1;
            if (a_core_start) begin
                starts++;
                if (s < 0) s = 0;
                checks++; if (a_core_op !== c_BUNDLE0) begin failures++; $display("FAIL single_core_op got=%h exp=%h", a_core_op, c_BUNDLE0); end
            end
            if (a_rsp_valid) rsp_s = s;
        end
        core_done = 1'b0;
        checks++; if (starts !== 1) begin failures++; $display("FAIL single_start_count got=%0d exp=1", starts); end
        checks++; if (rsp_s !== 21) begin failures++; $display("FAIL single_rsp_latency got=%0d exp=21", rsp_s); end
        checks++; if ({a_rsp_id, a_rsp_hit, a_rsp_tmo} !== 4'b0010) begin failures++; $display("FAIL single_rsp got id/hit/tmo=%b exp=0010", {a_rsp_id, a_rsp_hit, a_rsp_tmo}); end
        @(negedge clk); rsp_ready = 1'b1;
        @(negedge clk); rsp_ready = 1'b0; #1;
        checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL single_idle_after got=%b exp=0", a_busy); end
    endtask

    task automatic test_back_to_back();
        int exp_g[5] = '{0, 1, 2, 3, 0};
        logic [OPW-1:0] ops [NREQ];
        int s = -1; int ng = 0; int nr = 0;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            ops[i] = {6{32'hA5A50000 + 32'(i)}};
            req_op[i*OPW +: OPW] = ops[i];
        end
        rsp_ready = 1'b1;
        for (int c = 0; c < 200 && nr < 5; c++) begin
            @(negedge clk);
            req_valid = 4'b1111;
            if (s >= 0) s++;
            core_done = (s == 5);
            #1;
            if (|a_req_ready && ng < 5) begin
                checks++;
                if (a_req_ready !== 4'(1 << exp_g[ng])) begin failures++; $display("FAIL rr_grant%0d got=%b exp_idx=%0d", ng, a_req_ready, exp_g[ng]); end
                ng++;
            end
            if (a_core_start) begin
                s = 0;
                checks++;
                if (a_core_op !== ops[exp_g[ng-1]]) begin failures++; $display("FAIL rr_core_op%0d got=%h exp=%h", ng - 1, a_core_op, ops[exp_g[ng-1]]); end
            end
            if (a_rsp_valid) begin
                checks++;
                if (a_rsp_id !== 2'(exp_g[nr])) begin failures++; $display("FAIL rr_rsp_id%0d got=%0d exp=%0d", nr, a_rsp_id, exp_g[nr]); end
                nr++;
            end
            if (core_done) s = -1;
        end
        core_done = 1'b0; rsp_ready = 1'b0; req_valid = '0;
        checks++; if (nr !== 5 || ng !== 5) begin failures++; $display("FAIL rr_count got grants=%0d rsps=%0d exp=5/5", ng, nr); end
    endtask

    task automatic run_tmo(input string name, input int done_at, input logic exp_hit,
                           input logic exp_tmo, input int exp_aborts);
        int s = -1; int aborts = 0; int ab_s = -1; int rsp_s = -1;
        do_reset();
        @(negedge clk);
        req_valid = 4'b0001; req_op[0 +: OPW] = c_BUNDLE0; core_ret = 1'b1;
        for (int c = 0; c < 60 && (rsp_s < 0 || c < 30); c++) begin
            @(negedge clk);
            req_valid = '0;
            if (s >= 0) s++;
            core_done = (s == done_at);
            #1;
            if (t_core_start && s < 0) s = 0;
            if (t_core_abort) begin aborts++; ab_s = s; end
            if (t_rsp_valid && rsp_s < 0) rsp_s = s;
        end
        core_done = 1'b0;
        checks++; if (aborts !== exp_aborts) begin failures++; $display("FAIL %s_abort_count got=%0d exp=%0d", name, aborts, exp_aborts); end
        if (exp_aborts == 1) begin
            checks++; if (ab_s !== 16) begin failures++; $display("FAIL %s_abort_cycle got=%0d exp=16", name, ab_s); end
        end
        checks++; if (rsp_s !== 17) begin failures++; $display("FAIL %s_rsp_cycle got=%0d exp=17", name, rsp_s); end
        checks++; if ({t_rsp_valid, t_rsp_hit, t_rsp_tmo} !== {1'b1, exp_hit, exp_tmo}) begin
            failures++; $display("FAIL %s_rsp got valid/hit/tmo=%b exp=%b", name, {t_rsp_valid, t_rsp_hit, t_rsp_tmo}, {1'b1, exp_hit, exp_tmo}); end
    endtask

    task automatic test_timeout();
        run_tmo("tmo", -100, 1'b0, 1'b1, 1);
    endtask

    task automatic test_done_at_timeout();
        run_tmo("tie", 16, 1'b1, 1'b0, 0);
    endtask

    task automatic test_stall();
        int s = -1; int rsp_s = -1;
        do_reset();
        @(negedge clk);
        req_valid = 4'b0100; req_op[2*OPW +: OPW] = c_BUNDLE0; core_ret = 1'b0;
        for (int c = 0; c < 30 && rsp_s < 0; c++) begin
            @(negedge clk);
            req_valid = '0;
            if (s >= 0) s++;
            core_done = (s == 3);
            #1;
            if (a_core_start && s < 0) s = 0;
            if (a_rsp_valid) rsp_s = s;
        end
        checks++; if (rsp_s !== 4) begin failures++; $display("FAIL stall_rsp_cycle got=%0d exp=4", rsp_s); end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            req_valid = 4'b1111; rsp_ready = 1'b0; core_ret = 1'b1;
            core_done = (k == 4);
            #1;
            checks++;
            if ({a_rsp_valid, a_rsp_id, a_rsp_hit, a_rsp_tmo} !== 5'b11000 || a_req_ready !== 4'b0 || a_core_start !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold%0d got v/id/hit/tmo=%b ready=%b start=%b exp=11000/0000/0", k,
                         {a_rsp_valid, a_rsp_id, a_rsp_hit, a_rsp_tmo}, a_req_ready, a_core_start);
            end
        end
        @(negedge clk); core_done = 1'b0; rsp_ready = 1'b1; #1;
        checks++; if (a_req_ready !== 4'b0) begin failures++; $display("FAIL stall_accept_ready got=%b exp=0000", a_req_ready); end
        @(negedge clk); rsp_ready = 1'b0; #1;
        checks++; if (a_req_ready !== 4'b1000) begin failures++; $display("FAIL stall_next_grant got=%b exp=1000", a_req_ready); end
        req_valid = '0;
    endtask

    task automatic test_async_reset();
        do_reset();
        @(negedge clk);
        req_valid = 4'b0010; req_op[1*OPW +: OPW] = c_BUNDLE0;
        repeat (5) begin
            @(negedge clk);
            req_valid = '0; core_done = 1'b0;
        end
        #1;
        checks++; if (a_busy !== 1'b1 || a_rsp_id !== 2'd1) begin failures++; $display("FAIL areset_pre got busy=%b id=%0d exp=1/1", a_busy, a_rsp_id); end
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({a_busy, a_core_start, a_core_abort, a_rsp_valid, a_rsp_hit, a_rsp_tmo} !== 6'b0 ||
            a_rsp_id !== 2'd0 || a_core_op !== '0 || a_req_ready !== 4'b0) begin
            failures++;
            $display("FAIL areset_outputs got busy/start/abort/valid/hit/tmo=%b id=%0d op=%h ready=%b exp=all zero",
                     {a_busy, a_core_start, a_core_abort, a_rsp_valid, a_rsp_hit, a_rsp_tmo}, a_rsp_id, a_core_op, a_req_ready);
        end
        @(negedge clk);
        rst = 1'b1; req_valid = 4'b1111;
        #1;
        checks++; if (a_req_ready !== 4'b0001) begin failures++; $display("FAIL areset_next_grant got=%b exp=0001", a_req_ready); end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_done_at_timeout();
        test_stall();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
